data_memory_dp: RTL
===================

Name: data_memory_dp

Overview:
Parametrised successor to the CPU's 8-bit, 32-entry data memory. Port A is a read/write access port with a registered 1-cycle read. Port B is a read-only port with a registered 1-cycle read, used by debug/DMA.
- A built-in clear engine zeroes the whole array after reset and whenever Clr is requested.
- Both ports are gated by Ready.

Parameters:
DATA_W, 8, data word width in bits
ADDR_W, 5, address width in bits
DEPTH, 32, number of implemented words; legal range 1..2**ADDR_W
WRITE_FIRST, 0, same-address A-write/B-read collision: 1 = B returns new data, 0 = B returns old data

Ports:
Clk  in  1  clock, all state updates on rising edge
Rst_n  in  1  asynchronous active-low reset
Clr  in  1  one-cycle request to re-clear the array; sampled only when Ready=1
Ready  out  1  1 = accesses accepted; 0 while the clear engine runs
A_Req  in  1  port A access request
A_We  in  1  port A write (1) / read (0)
A_Address  in  ADDR_W  port A word address
A_Data_in  in  DATA_W  port A write data
A_Data_out  out  DATA_W  port A registered read data
A_Rd_valid  out  1  one-cycle pulse: A_Data_out updated by a read
B_Req  in  1  port B read request
B_Address  in  ADDR_W  port B word address
B_Data_out  out  DATA_W  port B registered read data
B_Rd_valid  out  1  one-cycle pulse: B_Data_out updated
Addr_err  out  1  one-cycle pulse: an accepted access on either port had address >= DEPTH

Behaviour:
- Reset (Rst_n=0, asynchronous) applies to control registers only; the array itself is not reset:
  - State=CLEAR, clear counter=0.
  - Ready=0, A_Rd_valid=0, B_Rd_valid=0, Addr_err=0, A_Data_out=0, B_Data_out=0.
- FSM has two states, CLEAR and RUN:
  - CLEAR: each cycle write 0 to mem[counter] and increment the counter. After the edge that writes DEPTH-1, go to RUN. A clear takes exactly DEPTH cycles.
  - RUN: Ready=1. If Clr=1 at an edge, go to CLEAR with counter=0. An access presented in that same cycle is still performed.
- Ready is a registered output, equal to 1 only in RUN.
- All requests (A_Req, B_Req, Clr) seen while Ready=0 are ignored: no array change, no Rd_valid, no Addr_err.
- Accepted A write (A_Req & A_We & Ready at edge N): mem[A_Address] <= A_Data_in at edge N. A_Rd_valid=0 and A_Data_out is unchanged.
- Accepted A read (A_Req & ~A_We & Ready at edge N): A_Data_out = mem[A_Address] and A_Rd_valid=1 during cycle N+1 only.
- Port B read follows the same timing as an A read.
- Read-after-write on consecutive cycles returns the new data.
- Same-address collision (A write + B read at the same edge): B_Data_out = A_Data_in if WRITE_FIRST=1, else the previous content.
- A and B reading the same address in the same cycle: both return the same value.
- Data_out registers hold their last value when no read is accepted.
- Out of range (address >= DEPTH, possible only if DEPTH < 2**ADDR_W):
  - Write is dropped.
  - Read returns 0 with Rd_valid=1.
  - Addr_err pulses in cycle N+1. It is the OR over both ports.
- Reset asserted mid-clear or mid-access: immediate return to the reset values. After release, a full DEPTH-cycle clear runs.
- The counter is ADDR_W+1 bits wide so it cannot wrap when DEPTH = 2**ADDR_W.

Decomposition:
- Package data_mem_pkg holds:
  - state typedef (CLEAR, RUN)
  - collision-mode constants WRITE_FIRST_C=1 and READ_FIRST_C=0
- One sub-module, data_mem_dp_core: the array plus one write port and two registered read ports, including collision muxing. The top holds the FSM, the clear counter, request gating, range checks and Addr_err.

Test Plan:
- Release Rst_n (defaults) -> Ready=0 for 32 cycles, 1 from cycle 33; A read addr 31 -> A_Data_out=0x00, A_Rd_valid=1 the next cycle.
- A write 0xA5 to addr 3, then A read addr 3 the following cycle -> A_Data_out=0xA5 one cycle after the read request; A_Rd_valid high exactly 1 cycle.
- With mem[7]=0xA5: A write 0x5A to addr 7 and B read addr 7 in the same cycle -> B_Data_out=0xA5 (WRITE_FIRST=0); rerun with WRITE_FIRST=1 -> 0x5A.
- Clr pulse in RUN with mem[3]=0xA5 -> Ready=0 for 32 cycles; A_Req during that window gives no Rd_valid; afterwards A read addr 3 -> 0x00.
- Rst_n low at clear count 10 -> Ready/Rd_valid/Data_out go to 0 with no clock edge; after release a full 32-cycle clear runs.
- DEPTH=20, ADDR_W=5: A write 0xFF to addr 25 then read addr 25 -> A_Data_out=0x00, A_Rd_valid=1, Addr_err pulses once per access; mem[0..19] unchanged.

Source files
------------

// File: rtl/data_mem_pkg.sv
// Shared types for the dual-port data memory.
// Holds the controller state and collision-mode constants.
package data_mem_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_e;

  localparam bit WRITE_FIRST_C = 1'b1;
  localparam bit READ_FIRST_C  = 1'b0;

endpackage

// File: rtl/data_mem_dp_core.sv
// Storage array with one write port and two registered read ports.
// Ports: clk_i, rst_n_i, we_i/waddr_i/wdata_i write port;
//   a_re_i/a_ok_i/a_raddr_i -> a_rdata_o, b_re_i/b_ok_i/b_raddr_i -> b_rdata_o.
module data_mem_dp_core
  import data_mem_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 5,
  parameter int DEPTH       = 32,
  parameter bit WRITE_FIRST = READ_FIRST_C
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              a_re_i,
  input  logic              a_ok_i,
  input  logic [ADDR_W-1:0] a_raddr_i,
  input  logic              b_re_i,
  input  logic              b_ok_i,
  input  logic [ADDR_W-1:0] b_raddr_i,
  output logic [DATA_W-1:0] a_rdata_o,
  output logic [DATA_W-1:0] b_rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [DATA_W-1:0] a_rdata_q;
  logic [DATA_W-1:0] a_rdata_d;
  logic [DATA_W-1:0] b_rdata_q;
  logic [DATA_W-1:0] b_rdata_d;
  logic              b_fwd;

  // The array has no reset; the clear engine zeroes it.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Same-edge write to the B address: hand B the new word
  // only in write-first mode.
  assign b_fwd = (WRITE_FIRST == WRITE_FIRST_C)
               && we_i
               && (waddr_i == b_raddr_i);

  always_comb begin
    a_rdata_d = a_rdata_q;
    if (a_re_i) begin
      a_rdata_d = a_ok_i ? mem_q[a_raddr_i] : '0;
    end
  end

  always_comb begin
    b_rdata_d = b_rdata_q;
    if (b_re_i) begin
      if (!b_ok_i) begin
        b_rdata_d = '0;
      end else if (b_fwd) begin
        b_rdata_d = wdata_i;
      end else begin
        b_rdata_d = mem_q[b_raddr_i];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      a_rdata_q <= '0;
      b_rdata_q <= '0;
    end else begin
      a_rdata_q <= a_rdata_d;
      b_rdata_q <= b_rdata_d;
    end
  end

  assign a_rdata_o = a_rdata_q;
  assign b_rdata_o = b_rdata_q;

endmodule

// File: rtl/data_memory_dp.sv
// Dual-port data memory: port A read/write, port B read-only, clear engine.
// Ports: Clk, Rst_n, Clr, Ready; A_Req/A_We/A_Address/A_Data_in ->
//   A_Data_out/A_Rd_valid; B_Req/B_Address -> B_Data_out/B_Rd_valid; Addr_err.
module data_memory_dp
  import data_mem_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 5,
  parameter int DEPTH       = 32,
  parameter bit WRITE_FIRST = READ_FIRST_C
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              Clr,
  output logic              Ready,
  input  logic              A_Req,
  input  logic              A_We,
  input  logic [ADDR_W-1:0] A_Address,
  input  logic [DATA_W-1:0] A_Data_in,
  output logic [DATA_W-1:0] A_Data_out,
  output logic              A_Rd_valid,
  input  logic              B_Req,
  input  logic [ADDR_W-1:0] B_Address,
  output logic [DATA_W-1:0] B_Data_out,
  output logic              B_Rd_valid,
  output logic              Addr_err
);

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] LAST_L  = (ADDR_W+1)'(DEPTH-1);

  state_e state_q;
  state_e state_d;

  // One bit wider than the address so DEPTH = 2**ADDR_W never wraps.
  logic [ADDR_W:0] cnt_q;
  logic [ADDR_W:0] cnt_d;

  logic ready_q;
  logic ready_d;
  logic a_vld_q;
  logic b_vld_q;
  logic err_q;

  logic a_acc;
  logic a_wr;
  logic a_rd;
  logic a_ok;
  logic b_rd;
  logic b_ok;
  logic err_d;

  logic              clr_we;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;

  // Every request is gated by the registered Ready.
  assign a_acc = A_Req & ready_q;
  assign a_wr  = a_acc & A_We;
  assign a_rd  = a_acc & ~A_We;
  assign b_rd  = B_Req & ready_q;

  assign a_ok = ({1'b0, A_Address} < DEPTH_L);
  assign b_ok = ({1'b0, B_Address} < DEPTH_L);

  assign err_d = (a_acc & ~a_ok) | (b_rd & ~b_ok);

  // Clear writes and port A writes never overlap:
  // port A is blocked whenever the engine runs.
  assign clr_we = (state_q == CLEAR);
  assign we     = clr_we | (a_wr & a_ok);
  assign waddr  = clr_we ? cnt_q[ADDR_W-1:0] : A_Address;
  assign wdata  = clr_we ? '0 : A_Data_in;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      CLEAR: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_L) begin
          state_d = RUN;
          cnt_d   = '0;
        end
      end
      RUN: begin
        if (Clr) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
    endcase
    ready_d = (state_d == RUN);
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
      ready_q <= 1'b0;
      a_vld_q <= 1'b0;
      b_vld_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      a_vld_q <= a_rd;
      b_vld_q <= b_rd;
      err_q   <= err_d;
    end
  end

  data_mem_dp_core #(
    .DATA_W     (DATA_W),
    .ADDR_W     (ADDR_W),
    .DEPTH      (DEPTH),
    .WRITE_FIRST(WRITE_FIRST)
  ) u_core (
    .clk_i    (Clk),
    .rst_n_i  (Rst_n),
    .we_i     (we),
    .waddr_i  (waddr),
    .wdata_i  (wdata),
    .a_re_i   (a_rd),
    .a_ok_i   (a_ok),
    .a_raddr_i(A_Address),
    .b_re_i   (b_rd),
    .b_ok_i   (b_ok),
    .b_raddr_i(B_Address),
    .a_rdata_o(A_Data_out),
    .b_rdata_o(B_Data_out)
  );

  assign Ready      = ready_q;
  assign A_Rd_valid = a_vld_q;
  assign B_Rd_valid = b_vld_q;
  assign Addr_err   = err_q;

endmodule
